// File: rtl/pipe_control_pkg.sv
// Shared control-word types, opcode patterns and encodings
// for the pipelined LEGv8-subset control unit.
package cpu_ctrl_pkg;

   localparam int OPC_W    = 11;
   localparam int REG_W    = 5;
   localparam int ALUSRC_W = 3;
   localparam int ALUOP_W  = 2;

   localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

   localparam logic [ALUSRC_W-1:0] SRC_REG   = 3'b000;
   localparam logic [ALUSRC_W-1:0] SRC_IMM12 = 3'b001;
   localparam logic [ALUSRC_W-1:0] SRC_SHAMT = 3'b010;
   localparam logic [ALUSRC_W-1:0] SRC_MUL   = 3'b011;
   localparam logic [ALUSRC_W-1:0] SRC_DADDR = 3'b100;

   localparam logic [ALUOP_W-1:0] OP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] OP_PASSB = 2'b01;
   localparam logic [ALUOP_W-1:0] OP_FUNC  = 2'b10;

   // Opcode patterns as mask/value pairs; mask bits of 0 are don't-care
   localparam logic [OPC_W-1:0] RTYPE_M = 11'b10001111111;
   localparam logic [OPC_W-1:0] RTYPE_V = 11'b10001011000;
   localparam logic [OPC_W-1:0] ADDI_M  = 11'b11111111110;
   localparam logic [OPC_W-1:0] ADDI_V  = 11'b10010001000;
   localparam logic [OPC_W-1:0] SHIFT_M = 11'b11111111110;
   localparam logic [OPC_W-1:0] SHIFT_V = 11'b11010011010;
   localparam logic [OPC_W-1:0] FULL_M  = 11'b11111111111;
   localparam logic [OPC_W-1:0] LDUR_V  = 11'b11111000010;
   localparam logic [OPC_W-1:0] STUR_V  = 11'b11111000000;
   localparam logic [OPC_W-1:0] CBZ_M   = 11'b11111111000;
   localparam logic [OPC_W-1:0] CBZ_V   = 11'b10110100000;
   localparam logic [OPC_W-1:0] BLT_M   = 11'b11111111000;
   localparam logic [OPC_W-1:0] BLT_V   = 11'b01010100000;
   localparam logic [OPC_W-1:0] B_M     = 11'b11111100000;
   localparam logic [OPC_W-1:0] B_V     = 11'b00010100000;

   typedef struct packed {
      logic                valid;
      logic                reg2loc;
      logic                reads_r2;
      logic [ALUSRC_W-1:0] alusrc;
      logic [ALUOP_W-1:0]  aluop;
      logic                shift_dir;
      logic                uncond_br;
      logic                cbz;
      logic                blt;
      logic                mem_write;
      logic                mem_read_en;
      logic                reg_write_en;
      logic                mem_to_reg;
      logic [REG_W-1:0]    rd;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic logic op_is(
      input logic [OPC_W-1:0] op,
      input logic [OPC_W-1:0] m,
      input logic [OPC_W-1:0] v
   );
      return (op & m) == v;
   endfunction

endpackage

// File: rtl/pipe_control_if.sv
// ID/EX/MEM/WB control bundle between the datapath
// front end (master) and the pipelined control unit (slave).
interface pipe_control_if;
   import cpu_ctrl_pkg::*;

   logic                id_valid;
   logic [OPC_W-1:0]    id_opCode;
   logic [REG_W-1:0]    id_rn;
   logic [REG_W-1:0]    id_rm;
   logic [REG_W-1:0]    id_rd;
   logic                ex_zero;
   logic                ex_negative;
   logic                ex_overflow;

   logic                id_Reg2Loc;
   logic                stall;
   logic                flush;
   logic [ALUSRC_W-1:0] ex_ALUSrc;
   logic [ALUOP_W-1:0]  ex_ALUOp;
   logic                ex_shiftDir;
   logic                ex_UncondBr;
   logic                ex_CBZ;
   logic                ex_bLT;
   logic                brTaken;
   logic                mem_MemWrite;
   logic                mem_MemReadEn;
   logic                wb_RegWriteEn;
   logic                wb_MemToReg;
   logic [REG_W-1:0]    wb_rd;

   modport master (
      output id_valid, id_opCode,
      output id_rn, id_rm, id_rd,
      output ex_zero, ex_negative, ex_overflow,
      input  id_Reg2Loc, stall, flush,
      input  ex_ALUSrc, ex_ALUOp,
      input  ex_shiftDir, ex_UncondBr,
      input  ex_CBZ, ex_bLT, brTaken,
      input  mem_MemWrite, mem_MemReadEn,
      input  wb_RegWriteEn, wb_MemToReg, wb_rd
   );

   modport slave (
      input  id_valid, id_opCode,
      input  id_rn, id_rm, id_rd,
      input  ex_zero, ex_negative, ex_overflow,
      output id_Reg2Loc, stall, flush,
      output ex_ALUSrc, ex_ALUOp,
      output ex_shiftDir, ex_UncondBr,
      output ex_CBZ, ex_bLT, brTaken,
      output mem_MemWrite, mem_MemReadEn,
      output wb_RegWriteEn, wb_MemToReg, wb_rd
   );

endinterface

// File: rtl/pipe_control_decode.sv
// Combinational opcode to control-word decoder for ID.
// Unknown opcodes and invalid slots decode to a bubble.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic             valid,
   input  logic [OPC_W-1:0] opcode,
   input  logic [REG_W-1:0] rd,
   output ctrl_t            ctrl
);

   always_comb begin
      ctrl = CTRL_BUBBLE;
      if (valid) begin
         unique case (1'b1)
            op_is(opcode, RTYPE_M, RTYPE_V): begin
               ctrl.valid        = 1'b1;
               ctrl.reg2loc      = 1'b1;
               ctrl.reads_r2     = 1'b1;
               ctrl.alusrc       = opcode[7] ? SRC_MUL
                                             : SRC_REG;
               ctrl.aluop        = OP_FUNC;
               ctrl.reg_write_en = 1'b1;
               ctrl.rd           = rd;
            end
            op_is(opcode, ADDI_M, ADDI_V): begin
               ctrl.valid        = 1'b1;
               ctrl.reg2loc      = 1'b1;
               ctrl.alusrc       = SRC_IMM12;
               ctrl.aluop        = OP_FUNC;
               ctrl.reg_write_en = 1'b1;
               ctrl.rd           = rd;
            end
            op_is(opcode, SHIFT_M, SHIFT_V): begin
               ctrl.valid        = 1'b1;
               ctrl.alusrc       = SRC_SHAMT;
               ctrl.aluop        = OP_FUNC;
               ctrl.shift_dir    = ~opcode[0];
               ctrl.reg_write_en = 1'b1;
               ctrl.rd           = rd;
            end
            op_is(opcode, FULL_M, LDUR_V): begin
               ctrl.valid        = 1'b1;
               ctrl.alusrc       = SRC_DADDR;
               ctrl.aluop        = OP_ADD;
               ctrl.mem_read_en  = 1'b1;
               ctrl.mem_to_reg   = 1'b1;
               ctrl.reg_write_en = 1'b1;
               ctrl.rd           = rd;
            end
            op_is(opcode, FULL_M, STUR_V): begin
               ctrl.valid        = 1'b1;
               ctrl.reads_r2     = 1'b1;
               ctrl.alusrc       = SRC_DADDR;
               ctrl.aluop        = OP_ADD;
               ctrl.mem_write    = 1'b1;
            end
            op_is(opcode, CBZ_M, CBZ_V): begin
               ctrl.valid        = 1'b1;
               ctrl.reads_r2     = 1'b1;
               ctrl.cbz          = 1'b1;
               ctrl.aluop        = OP_PASSB;
            end
            op_is(opcode, BLT_M, BLT_V): begin
               ctrl.valid        = 1'b1;
               ctrl.blt          = 1'b1;
               ctrl.aluop        = OP_FUNC;
            end
            op_is(opcode, B_M, B_V): begin
               ctrl.valid        = 1'b1;
               ctrl.uncond_br    = 1'b1;
               ctrl.alusrc       = SRC_DADDR;
               ctrl.aluop        = OP_ADD;
            end
            default: ctrl = CTRL_BUBBLE;
         endcase
      end
   end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control: ID decode, ID/EX/MEM/WB control registers,
// load-use stall detection and EX branch resolution.
module pipe_control
   import cpu_ctrl_pkg::*;
#(
   parameter bit HAZARD_EN = 1'b1
) (
   input logic           clk,
   input logic           reset_n,
   pipe_control_if.slave bus
);

   ctrl_t            id_c;
   ctrl_t            ex_q;
   ctrl_t            mem_q;
   ctrl_t            wb_q;
   logic [REG_W-1:0] r2_addr;
   logic             br_taken;
   logic             load_use;
   logic             stall;
   logic             unused_ok;

   ctrl_decode u_dec (
      .valid  (bus.id_valid),
      .opcode (bus.id_opCode),
      .rd     (bus.id_rd),
      .ctrl   (id_c)
   );

   // STUR/CBZ read their Rd field through the second read port
   assign r2_addr = id_c.reg2loc ? bus.id_rm
                                 : bus.id_rd;

   assign br_taken = ex_q.uncond_br
                   | (ex_q.cbz & bus.ex_zero)
                   | (ex_q.blt & (bus.ex_negative
                                  ^ bus.ex_overflow));

   assign load_use = ex_q.valid
                   & ex_q.mem_read_en
                   & (ex_q.rd != ZERO_REG)
                   & id_c.valid
                   & ((ex_q.rd == bus.id_rn)
                      | (id_c.reads_r2
                         & (ex_q.rd == r2_addr)));

   // A taken branch kills the ID slot, so it never stalls
   assign stall = HAZARD_EN & load_use & ~br_taken;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_q  <= CTRL_BUBBLE;
         mem_q <= CTRL_BUBBLE;
         wb_q  <= CTRL_BUBBLE;
      end else begin
         ex_q  <= (stall | br_taken) ? CTRL_BUBBLE
                                     : id_c;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   assign bus.id_Reg2Loc    = id_c.reg2loc;
   assign bus.stall         = stall;
   assign bus.flush         = br_taken;
   assign bus.brTaken       = br_taken;
   assign bus.ex_ALUSrc     = ex_q.alusrc;
   assign bus.ex_ALUOp      = ex_q.aluop;
   assign bus.ex_shiftDir   = ex_q.shift_dir;
   assign bus.ex_UncondBr   = ex_q.uncond_br;
   assign bus.ex_CBZ        = ex_q.cbz;
   assign bus.ex_bLT        = ex_q.blt;
   assign bus.mem_MemWrite  = mem_q.mem_write;
   assign bus.mem_MemReadEn = mem_q.mem_read_en;
   assign bus.wb_RegWriteEn = wb_q.reg_write_en;
   assign bus.wb_MemToReg   = wb_q.mem_to_reg;
   assign bus.wb_rd         = wb_q.rd;

   assign unused_ok = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: decode table, load-use, branch
// and reset sequences with a per-stage scoreboard.
module tb_pipe_control;
   import cpu_ctrl_pkg::*;

   typedef struct packed {
      logic [2:0] s;
      logic [1:0] o;
      logic       shd;
      logic       ubr;
      logic       cbz;
      logic       blt;
      logic       mw;
      logic       mr;
      logic       rwe;
      logic       m2r;
      logic [4:0] rd;
   } exp_t;

   typedef struct {
      logic [10:0] opc;
      logic        v;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [4:0]  rd;
      logic        r2l;
      exp_t        e;
   } vec_t;

   localparam exp_t BUB = '0;
   localparam logic [10:0] O_ADD  = 11'b10001011000;
   localparam logic [10:0] O_ADDI = 11'b10010001000;
   localparam logic [10:0] O_LDUR = 11'b11111000010;
   localparam logic [10:0] O_STUR = 11'b11111000000;
   localparam logic [10:0] O_CBZ  = 11'b10110100000;
   localparam logic [10:0] O_BLT  = 11'b01010100011;
   localparam logic [10:0] O_B    = 11'b00010100000;

   logic clk = 1'b0;
   logic reset_n;
   bit   run = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t q_ex[$];
   exp_t q_mem[$];
   exp_t q_wb[$];
   vec_t tv[14];

   always #5 clk = ~clk;

   pipe_control_if b0 ();
   pipe_control_if b1 ();

   pipe_control #(.HAZARD_EN(1'b1)) u0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b0)
   );

   pipe_control #(.HAZARD_EN(1'b0)) u1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b1)
   );

   assign b1.id_valid    = b0.id_valid;
   assign b1.id_opCode   = b0.id_opCode;
   assign b1.id_rn       = b0.id_rn;
   assign b1.id_rm       = b0.id_rm;
   assign b1.id_rd       = b0.id_rd;
   assign b1.ex_zero     = b0.ex_zero;
   assign b1.ex_negative = b0.ex_negative;
   assign b1.ex_overflow = b0.ex_overflow;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
      end
   endtask

   function automatic exp_t mk(
      input logic [2:0] s, input logic [1:0] o,
      input logic shd, ubr, cbz, blt,
      input logic mw, mr, rwe, m2r,
      input logic [4:0] rd);
      mk = {s, o, shd, ubr, cbz, blt, mw, mr, rwe, m2r, rd};
   endfunction

   always @(negedge clk)
      if (run) chk("nohaz_stall", {31'd0, b1.stall}, 0);

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (q_wb.size() > 0) begin
         e = q_wb.pop_front();
         chk("wb", {b0.wb_RegWriteEn, b0.wb_MemToReg,
                    b0.wb_rd}, {e.rwe, e.m2r, e.rd});
      end
      if (q_mem.size() > 0) begin
         e = q_mem.pop_front();
         chk("mem", {b0.mem_MemWrite, b0.mem_MemReadEn},
             {e.mw, e.mr});
         q_wb.push_back(e);
      end
      if (q_ex.size() > 0) begin
         e = q_ex.pop_front();
         chk("ex", {b0.ex_ALUSrc, b0.ex_ALUOp,
                    b0.ex_shiftDir, b0.ex_UncondBr,
                    b0.ex_CBZ, b0.ex_bLT},
             {e.s, e.o, e.shd, e.ubr, e.cbz, e.blt});
         q_mem.push_back(e);
      end
   endtask

   task automatic drive(input logic [10:0] opc,
                        input logic v,
                        input logic [4:0] rn, rm, rd,
                        input logic r2l,
                        input exp_t e,
                        input logic st, fl,
                        input string nm);
      b0.id_opCode = opc;
      b0.id_valid  = v;
      b0.id_rn     = rn;
      b0.id_rm     = rm;
      b0.id_rd     = rd;
      #1;
      chk({nm, ".r2l"}, {31'd0, b0.id_Reg2Loc}, {31'd0, r2l});
      chk({nm, ".stall"}, {31'd0, b0.stall}, {31'd0, st});
      chk({nm, ".flush"}, {31'd0, b0.flush}, {31'd0, fl});
      chk({nm, ".br"}, {31'd0, b0.brTaken}, {31'd0, fl});
      q_ex.push_back((st || fl) ? BUB : e);
      tick();
   endtask

   task automatic bub(input logic st, fl, input string nm);
      drive(11'd0, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0,
            BUB, st, fl, nm);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q_ex.delete();
      q_mem.delete();
      q_wb.delete();
      @(posedge clk);
      #1;
      chk("rst.ex", {b0.ex_ALUSrc, b0.ex_ALUOp,
                     b0.ex_shiftDir, b0.ex_UncondBr,
                     b0.ex_CBZ, b0.ex_bLT}, 0);
      chk("rst.mem", {b0.mem_MemWrite, b0.mem_MemReadEn}, 0);
      chk("rst.wb", {b0.wb_RegWriteEn, b0.wb_MemToReg,
                     b0.wb_rd}, 0);
      chk("rst.sfb", {b0.stall, b0.flush, b0.brTaken}, 0);
      reset_n = 1'b1;
      q_mem.push_back(BUB);
      q_wb.push_back(BUB);
   endtask

   initial begin
      exp_t ld5, add6, ld4, ld9, st0, ld8, addi2, ld31;
      exp_t cbz, blt, bb, st9, ld3;
      reset_n        = 1'b0;
      b0.id_valid    = 1'b0;
      b0.id_opCode   = '0;
      b0.id_rn       = '0;
      b0.id_rm       = '0;
      b0.id_rd       = '0;
      b0.ex_zero     = 1'b0;
      b0.ex_negative = 1'b0;
      b0.ex_overflow = 1'b0;
      do_reset();
      do_reset();
      run = 1'b1;

      tv[0]  = '{O_ADD, 1, 1, 2, 3, 1,
                 mk(3'b000, 2'b10, 0,0,0,0, 0,0,1,0, 3)};
      tv[1]  = '{11'b10011011000, 1, 1, 2, 4, 1,
                 mk(3'b011, 2'b10, 0,0,0,0, 0,0,1,0, 4)};
      tv[2]  = '{O_ADDI, 1, 1, 2, 3, 1,
                 mk(3'b001, 2'b10, 0,0,0,0, 0,0,1,0, 3)};
      tv[3]  = '{11'b10010001001, 1, 1, 2, 12, 1,
                 mk(3'b001, 2'b10, 0,0,0,0, 0,0,1,0, 12)};
      tv[4]  = '{11'b11010011011, 1, 1, 2, 6, 0,
                 mk(3'b010, 2'b10, 0,0,0,0, 0,0,1,0, 6)};
      tv[5]  = '{11'b11010011010, 1, 1, 2, 7, 0,
                 mk(3'b010, 2'b10, 1,0,0,0, 0,0,1,0, 7)};
      tv[6]  = '{O_LDUR, 1, 1, 2, 8, 0,
                 mk(3'b100, 2'b00, 0,0,0,0, 0,1,1,1, 8)};
      tv[7]  = '{O_STUR, 1, 1, 2, 9, 0,
                 mk(3'b100, 2'b00, 0,0,0,0, 1,0,0,0, 0)};
      tv[8]  = '{11'b10110100101, 1, 1, 2, 10, 0,
                 mk(3'b000, 2'b01, 0,0,1,0, 0,0,0,0, 0)};
      tv[9]  = '{O_BLT, 1, 1, 2, 11, 0,
                 mk(3'b000, 2'b10, 0,0,0,1, 0,0,0,0, 0)};
      tv[10] = '{11'b00010111111, 1, 1, 2, 13, 0,
                 mk(3'b100, 2'b00, 0,1,0,0, 0,0,0,0, 0)};
      tv[11] = '{11'b00000000000, 1, 1, 2, 14, 0, BUB};
      tv[12] = '{O_ADD, 0, 1, 2, 15, 0, BUB};
      tv[13] = '{11'b11111000011, 1, 1, 2, 16, 0, BUB};

      for (int i = 0; i < 14; i++) begin
         drive(tv[i].opc, tv[i].v, tv[i].rn, tv[i].rm,
               tv[i].rd, tv[i].r2l, tv[i].e, 1'b0, 1'b0,
               $sformatf("vec%0d", i));
         bub(1'b0, tv[i].e.ubr, $sformatf("gap%0d", i));
      end
      bub(0, 0, "drain");
      bub(0, 0, "drain");

      ld5   = mk(3'b100, 2'b00, 0,0,0,0, 0,1,1,1, 5);
      ld4   = mk(3'b100, 2'b00, 0,0,0,0, 0,1,1,1, 4);
      ld9   = mk(3'b100, 2'b00, 0,0,0,0, 0,1,1,1, 9);
      ld8   = mk(3'b100, 2'b00, 0,0,0,0, 0,1,1,1, 8);
      ld31  = mk(3'b100, 2'b00, 0,0,0,0, 0,1,1,1, 31);
      ld3   = mk(3'b100, 2'b00, 0,0,0,0, 0,1,1,1, 3);
      add6  = mk(3'b000, 2'b10, 0,0,0,0, 0,0,1,0, 6);
      addi2 = mk(3'b001, 2'b10, 0,0,0,0, 0,0,1,0, 2);
      st0   = mk(3'b100, 2'b00, 0,0,0,0, 1,0,0,0, 0);
      st9   = st0;
      cbz   = mk(3'b000, 2'b01, 0,0,1,0, 0,0,0,0, 0);
      blt   = mk(3'b000, 2'b10, 0,0,0,1, 0,0,0,0, 0);
      bb    = mk(3'b100, 2'b00, 0,1,0,0, 0,0,0,0, 0);

      drive(O_LDUR, 1, 1, 0, 5, 0, ld5, 0, 0, "lu_rn.ld");
      drive(O_ADD, 1, 5, 2, 6, 1, add6, 1, 0, "lu_rn.stall");
      drive(O_ADD, 1, 5, 2, 6, 1, add6, 0, 0, "lu_rn.go");
      bub(0, 0, "lu_rn.b");

      drive(O_LDUR, 1, 1, 0, 4, 0, ld4, 0, 0, "lu_rm.ld");
      drive(O_ADD, 1, 1, 4, 6, 1, add6, 1, 0, "lu_rm.stall");
      drive(O_ADD, 1, 1, 4, 6, 1, add6, 0, 0, "lu_rm.go");
      bub(0, 0, "lu_rm.b");

      drive(O_LDUR, 1, 1, 0, 9, 0, ld9, 0, 0, "lu_st.ld");
      drive(O_STUR, 1, 1, 0, 9, 0, st0, 1, 0, "lu_st.stall");
      drive(O_STUR, 1, 1, 0, 9, 0, st0, 0, 0, "lu_st.go");
      bub(0, 0, "lu_st.b");

      drive(O_LDUR, 1, 1, 0, 8, 0, ld8, 0, 0, "lu_imm.ld");
      drive(O_ADDI, 1, 1, 8, 2, 1, addi2, 0, 0, "lu_imm.no");
      bub(0, 0, "lu_imm.b");

      drive(O_LDUR, 1, 1, 0, 31, 0, ld31, 0, 0, "xzr.ld");
      drive(O_ADD, 1, 31, 31, 6, 1, add6, 0, 0, "xzr.no");
      bub(0, 0, "xzr.b");

      drive(O_CBZ, 1, 1, 0, 2, 0, cbz, 0, 0, "cbz1");
      b0.ex_zero = 1'b1;
      drive(O_ADD, 1, 1, 2, 7, 1, add6, 0, 1, "cbz1.kill");
      b0.ex_zero = 1'b0;
      bub(0, 0, "cbz1.b");
      drive(O_CBZ, 1, 1, 0, 2, 0, cbz, 0, 0, "cbz0");
      drive(O_ADD, 1, 1, 2, 6, 1, add6, 0, 0, "cbz0.keep");
      bub(0, 0, "cbz0.b");

      drive(O_BLT, 1, 1, 0, 2, 0, blt, 0, 0, "blt1");
      b0.ex_negative = 1'b1;
      bub(0, 1, "blt1.tk");
      b0.ex_negative = 1'b0;
      drive(O_BLT, 1, 1, 0, 2, 0, blt, 0, 0, "blt0");
      b0.ex_negative = 1'b1;
      b0.ex_overflow = 1'b1;
      bub(0, 0, "blt0.nt");
      b0.ex_negative = 1'b0;
      b0.ex_overflow = 1'b0;
      drive(O_B, 1, 1, 0, 2, 0, bb, 0, 0, "b");
      bub(0, 1, "b.tk");
      bub(0, 0, "b.drain");

      drive(O_STUR, 1, 1, 0, 9, 0, st9, 0, 0, "rst.st");
      drive(O_LDUR, 1, 1, 0, 3, 0, ld3, 0, 0, "rst.ld");
      b0.id_opCode = O_ADD;
      b0.id_valid  = 1'b1;
      b0.id_rn     = 5'd3;
      b0.id_rm     = 5'd2;
      b0.id_rd     = 5'd6;
      #1;
      chk("pre_rst.stall", {31'd0, b0.stall}, 1);
      chk("pre_rst.mw", {31'd0, b0.mem_MemWrite}, 1);
      do_reset();

      drive(O_B, 1, 1, 0, 2, 0, bb, 0, 0, "rst_br.b");
      chk("pre_rst.br", {31'd0, b0.brTaken}, 1);
      do_reset();
      bub(0, 0, "end");
      bub(0, 0, "end");

      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined successor to the single-cycle control decoder for the LEGv8-subset CPU. It decodes the 11-bit opcode in ID and carries the control word through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall) and resolves conditional branches in EX (flush). It sits between the fetch/decode front end and the pipelined datapath. Every output is defined for every opcode, so no latches are inferred.

## Interface
- OPC_W, 11, opcode width
- REG_W, 5, register-address width
- ZERO_REG, 31, register index hard-wired to zero (XZR); never causes a hazard
- ALUSRC_W, 3, ALUSrc select width
- ALUOP_W, 2, ALUOp width
- HAZARD_EN, 1, 1 = load-use detection on; 0 = stall tied to 0
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opCode  in  OPC_W  instruction[31:21]
- id_rn, id_rm, id_rd  in  REG_W  register fields of the ID instruction
- ex_zero, ex_negative, ex_overflow  in  1  ALU flags of the instruction in EX
- id_Reg2Loc  out  1  combinational, read-port-2 select for ID
- stall  out  1  hold PC and IF/ID; bubble into EX
- flush  out  1  kill IF/ID contents (branch taken in EX)
- ex_ALUSrc  out  ALUSRC_W; ex_ALUOp  out  ALUOP_W; ex_shiftDir, ex_UncondBr, ex_CBZ, ex_bLT  out  1
- brTaken  out  1  combinational, EX branch resolved taken
- mem_MemWrite, mem_MemReadEn  out  1
- wb_RegWriteEn, wb_MemToReg  out  1; wb_rd  out  REG_W

## Operation
- Decode table (opcode patterns; x = don't care). Any other opcode, or id_valid=0, decodes to a bubble: all enables 0, all fields 0.
  - R-type 1xxx1011000: Reg2Loc=1, ALUSrc=011 if op[7] else 000, ALUOp=10, RegWriteEn=1.
  - ADDI 1001000100x: Reg2Loc=1, ALUSrc=001, ALUOp=10, RegWriteEn=1.
  - Shift 1101001101x: ALUSrc=010, ALUOp=10, shiftDir=~op[0], RegWriteEn=1.
  - LDUR 11111000010: ALUSrc=100, ALUOp=00, MemReadEn=1, MemToReg=1, RegWriteEn=1.
  - STUR 11111000000: ALUSrc=100, ALUOp=00, Reg2Loc=0, MemWrite=1.
  - CBZ 10110100xxx: CBZ=1, Reg2Loc=0, ALUOp=01.
  - B.LT 01010100xxx: bLT=1, ALUOp=10.
  - B 000101xxxxx: UncondBr=1, ALUSrc=100, ALUOp=00.
- brTaken = ex_UncondBr | (ex_CBZ & ex_zero) | (ex_bLT & (ex_negative ^ ex_overflow)). flush = brTaken.
- Load-use: stall=1 when HAZARD_EN=1, EX holds a valid load with ex_rd != ZERO_REG, and ex_rd matches id_rn, or matches id_rm when the ID instruction reads Rm (R-type, STUR, CBZ use Rd-as-source via Reg2Loc=0).
- Register update each cycle:
  - EX←(stall|flush ? bubble : decoded ID).
  - MEM←EX.
  - WB←MEM.
  - wb_rd follows the destination register down the pipe.
- Simultaneous stall and flush: flush wins. The ID instruction is killed, stall is forced to 0, and the PC redirects.

## Timing
- Instruction in ID at cycle n: ex_* valid in n+1, mem_* in n+2, wb_* in n+3.
- id_Reg2Loc, stall, flush and brTaken are combinational in the same cycle; no registered feedback.
- Stall lasts exactly one cycle per load-use pair. The next cycle sees the load in MEM, so there is no match.
- Reset (reset_n=0 at a clock edge): all three stage registers become bubbles. All registered outputs are 0, and stall=flush=brTaken=0. Reset mid-stream discards every in-flight instruction, including a pending branch.

## Structure
- Package cpu_ctrl_pkg:
  - ctrl_t packed struct holding all control fields plus rd and valid.
  - Opcode pattern constants.
  - ALUSrc/ALUOp encodings.
  - CTRL_BUBBLE constant.
- Sub-module ctrl_decode: purely combinational opcode→ctrl_t with a full default assignment.
- pipe_control owns the three ctrl_t registers, the hazard unit and the branch resolution.

## Test plan
- ADDI 10010001000, rd=3, id_valid=1: ex_ALUSrc=001 and ex_ALUOp=10 at n+1; wb_RegWriteEn=1 and wb_rd=3 at n+3.
- LDUR rd=5, then ADD with rn=5: stall=1 for exactly one cycle, EX is a bubble that cycle, ADD reaches EX one cycle later. Repeat with rd=31: stall stays 0.
- CBZ in EX with ex_zero=1: brTaken=1 and flush=1, and the ID instruction never reaches EX. With ex_zero=0: no flush.
- B.LT in EX with negative=1, overflow=0: taken. With negative=1, overflow=1: not taken. Then B: always taken.
- Opcode 00000000000 with id_valid=1: all ex_/mem_/wb_ enables 0 at each stage.
- Assert reset_n=0 with STUR in MEM and LDUR in EX: the next cycle mem_MemWrite=0, wb_RegWriteEn=0, stall=0. Repeat with HAZARD_EN=0: stall is never asserted.
